// File: rtl/axi_slave_arbiter_if.sv
// Handshake bundle between two AXI masters, the arbiter and one shared slave.
// Payload buses (address, ID, LEN, data, STRB) stay outside and are muxed on SEL_M.
interface axi_slave_arbiter_if;
    // Master-facing handshakes, bit i belongs to master i
    logic [1:0] ARVALID_M;
    logic [1:0] ARREADY_M;
    logic [1:0] AWVALID_M;
    logic [1:0] AWREADY_M;
    logic [1:0] WVALID_M;
    logic [1:0] WLAST_M;
    logic [1:0] WREADY_M;
    logic [1:0] RVALID_M;
    logic [1:0] RREADY_M;
    logic [1:0] BVALID_M;
    logic [1:0] BREADY_M;

    // Slave-facing handshakes
    logic       ARVALID_S;
    logic       AWVALID_S;
    logic       WVALID_S;
    logic       RREADY_S;
    logic       BREADY_S;
    logic       ARREADY_S;
    logic       AWREADY_S;
    logic       WREADY_S;
    logic       RVALID_S;
    logic       RLAST_S;
    logic       BVALID_S;

    // The arbiter itself: a slave to the two masters, a master to the shared slave
    modport slave (
        input  ARVALID_M, AWVALID_M, WVALID_M, WLAST_M, RREADY_M, BREADY_M,
        input  ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, RLAST_S, BVALID_S,
        output ARREADY_M, AWREADY_M, WREADY_M, RVALID_M, BVALID_M,
        output ARVALID_S, AWVALID_S, WVALID_S, RREADY_S, BREADY_S
    );

    // The surrounding environment (masters plus slave) as seen from outside
    modport master (
        output ARVALID_M, AWVALID_M, WVALID_M, WLAST_M, RREADY_M, BREADY_M,
        output ARREADY_S, AWREADY_S, WREADY_S, RVALID_S, RLAST_S, BVALID_S,
        input  ARREADY_M, AWREADY_M, WREADY_M, RVALID_M, BVALID_M,
        input  ARVALID_S, AWVALID_S, WVALID_S, RREADY_S, BREADY_S
    );
endinterface

// File: rtl/axi_slave_arbiter.sv
// Two-master to one-slave AXI handshake arbiter. A granted transaction owns
// the slave from its address phase to its final handshake (RLAST or B).
// Masters are served round-robin on a tie; WR_FIRST picks write vs read
// inside one master. Only handshakes are switched here; payload muxes
// outside key on SEL_M.
module axi_slave_arbiter #(
    parameter bit WR_FIRST = 1'b1
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axi_slave_arbiter_if.slave bus,
    output logic               SEL_M,
    output logic               BUSY
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_RDATA = 3'd2,
        S_AW    = 3'd3,
        S_WDATA = 3'd4,
        S_BRESP = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;

    logic [1:0] elig;
    logic       grant;
    logic       grant_wr;
    logic [1:0] sel_oh;
    logic       ar_hs;
    logic       r_done;
    logic       aw_hs;
    logic       w_done;
    logic       b_done;

    // Arbitration among masters presenting an address request
    always_comb begin
        elig     = bus.ARVALID_M | bus.AWVALID_M;
        // On a tie the master that did not win last time goes next
        grant    = (elig == 2'b11) ? ~last_q : elig[1];
        grant_wr = WR_FIRST ? bus.AWVALID_M[grant] : ~bus.ARVALID_M[grant];
    end

    // Handshake completions of the selected master, qualified by state later
    always_comb begin
        sel_oh = sel_q ? 2'b10 : 2'b01;
        ar_hs  = bus.ARVALID_M[sel_q] & bus.ARREADY_S;
        r_done = bus.RVALID_S & bus.RREADY_M[sel_q] & bus.RLAST_S;
        aw_hs  = bus.AWVALID_M[sel_q] & bus.AWREADY_S;
        w_done = bus.WVALID_M[sel_q] & bus.WREADY_S & bus.WLAST_M[sel_q];
        b_done = bus.BVALID_S & bus.BREADY_M[sel_q];
    end

    // State, grant and round-robin registers; reset aborts any transaction
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // Next-state logic: grant only from IDLE, then walk the owned transaction
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (|elig) begin
                    state_d = grant_wr ? S_AW : S_AR;
                    sel_d   = grant;
                    last_d  = grant;
                end
            end
            // A dropped valid simply holds here; there is no regrant path
            S_AR:    if (ar_hs)  state_d = S_RDATA;
            S_RDATA: if (r_done) state_d = S_IDLE;
            S_AW:    if (aw_hs)  state_d = S_WDATA;
            S_WDATA: if (w_done) state_d = S_BRESP;
            S_BRESP: if (b_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake routing: only the phase matching the state is connected
    always_comb begin
        bus.ARREADY_M = 2'b00;
        bus.AWREADY_M = 2'b00;
        bus.WREADY_M  = 2'b00;
        bus.RVALID_M  = 2'b00;
        bus.BVALID_M  = 2'b00;
        bus.ARVALID_S = 1'b0;
        bus.AWVALID_S = 1'b0;
        bus.WVALID_S  = 1'b0;
        bus.RREADY_S  = 1'b0;
        bus.BREADY_S  = 1'b0;
        case (state_q)
            S_AR: begin
                bus.ARVALID_S = bus.ARVALID_M[sel_q];
                bus.ARREADY_M = sel_oh & {2{bus.ARREADY_S}};
            end
            S_RDATA: begin
                bus.RVALID_M  = sel_oh & {2{bus.RVALID_S}};
                bus.RREADY_S  = bus.RREADY_M[sel_q];
            end
            S_AW: begin
                bus.AWVALID_S = bus.AWVALID_M[sel_q];
                bus.AWREADY_M = sel_oh & {2{bus.AWREADY_S}};
            end
            S_WDATA: begin
                bus.WVALID_S  = bus.WVALID_M[sel_q];
                bus.WREADY_M  = sel_oh & {2{bus.WREADY_S}};
            end
            S_BRESP: begin
                bus.BVALID_M  = sel_oh & {2{bus.BVALID_S}};
                bus.BREADY_S  = bus.BREADY_M[sel_q];
            end
            default: begin
                bus.ARVALID_S = 1'b0;
            end
        endcase
    end

    // Status outputs
    always_comb begin
        SEL_M = sel_q;
        BUSY  = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_axi_slave_arbiter.sv
// Bench for axi_slave_arbiter: directed cycle table, multi-cycle corner
// sequences, and random traffic against a transaction-level reference model.
module tb_axi_slave_arbiter;

    localparam bit WR_FIRST = 1'b1;

    logic ACLK;
    logic ARESETn;
    logic SEL_M;
    logic BUSY;

    axi_slave_arbiter_if bus ();

    axi_slave_arbiter #(.WR_FIRST(WR_FIRST)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus),
        .SEL_M   (SEL_M),
        .BUSY    (BUSY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    typedef struct packed {
        logic [1:0] arv, awv, wv, wl, rr, br;
        logic       ars, aws, ws, rvs, rls, bvs;
    } in_t;

    typedef struct packed {
        logic [1:0] arr, awr, wr, rv, bv;
        logic       arv_s, awv_s, wv_s, rr_s, br_s, sel, busy;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Transaction-level reference: who owns the slave, what kind, which phase
    bit   m_busy;
    logic m_sel;
    logic m_last;
    bit   m_wr;
    int   m_ph;   // 0 address, 1 data, 2 write response

    task automatic drive(input in_t v);
        bus.ARVALID_M = v.arv;
        bus.AWVALID_M = v.awv;
        bus.WVALID_M  = v.wv;
        bus.WLAST_M   = v.wl;
        bus.RREADY_M  = v.rr;
        bus.BREADY_M  = v.br;
        bus.ARREADY_S = v.ars;
        bus.AWREADY_S = v.aws;
        bus.WREADY_S  = v.ws;
        bus.RVALID_S  = v.rvs;
        bus.RLAST_S   = v.rls;
        bus.BVALID_S  = v.bvs;
    endtask

    function automatic out_t sample();
        out_t o;
        o.arr   = bus.ARREADY_M;
        o.awr   = bus.AWREADY_M;
        o.wr    = bus.WREADY_M;
        o.rv    = bus.RVALID_M;
        o.bv    = bus.BVALID_M;
        o.arv_s = bus.ARVALID_S;
        o.awv_s = bus.AWVALID_S;
        o.wv_s  = bus.WVALID_S;
        o.rr_s  = bus.RREADY_S;
        o.br_s  = bus.BREADY_S;
        o.sel   = SEL_M;
        o.busy  = BUSY;
        return o;
    endfunction

    task automatic check_out(input string nm, input out_t act, input out_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic add(input in_t i, input out_t o);
        vec_t e;
        e.i = i;
        e.o = o;
        tbl.push_back(e);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        drive('0);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_sel  = 1'b0;
        m_last = 1'b1;
        m_wr   = 1'b0;
        m_ph   = 0;
    endtask

    function automatic out_t model_out(input in_t v);
        out_t o = '0;
        o.sel = m_sel;
        if (m_busy) begin
            o.busy = 1'b1;
            if (!m_wr && m_ph == 0) begin
                o.arv_s      = v.arv[m_sel];
                o.arr[m_sel] = v.ars;
            end else if (!m_wr && m_ph == 1) begin
                o.rv[m_sel]  = v.rvs;
                o.rr_s       = v.rr[m_sel];
            end else if (m_wr && m_ph == 0) begin
                o.awv_s      = v.awv[m_sel];
                o.awr[m_sel] = v.aws;
            end else if (m_wr && m_ph == 1) begin
                o.wv_s       = v.wv[m_sel];
                o.wr[m_sel]  = v.ws;
            end else begin
                o.bv[m_sel]  = v.bvs;
                o.br_s       = v.br[m_sel];
            end
        end
        return o;
    endfunction

    task automatic model_step(input in_t v);
        logic e0, e1, g;
        if (!m_busy) begin
            e0 = v.arv[0] | v.awv[0];
            e1 = v.arv[1] | v.awv[1];
            if (e0 || e1) begin
                g      = (e0 && e1) ? ~m_last : e1;
                m_busy = 1'b1;
                m_sel  = g;
                m_last = g;
                m_wr   = WR_FIRST ? v.awv[g] : !v.arv[g];
                m_ph   = 0;
            end
        end else if (!m_wr) begin
            if (m_ph == 0 && v.arv[m_sel] && v.ars) m_ph = 1;
            else if (m_ph == 1 && v.rvs && v.rr[m_sel] && v.rls) m_busy = 1'b0;
        end else begin
            if (m_ph == 0 && v.awv[m_sel] && v.aws) m_ph = 1;
            else if (m_ph == 1 && v.wv[m_sel] && v.ws && v.wl[m_sel]) m_ph = 2;
            else if (m_ph == 2 && v.bvs && v.br[m_sel]) m_busy = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  v;
        out_t o;
        int   beats;
        int   grants[$];
        logic prev_busy;
        logic pat[6];

        // Directed cycle table; in: arv awv wv wl rr br ars aws ws rvs rls bvs
        //                      out: arr awr wr rv bv arv_s awv_s wv_s rr_s br_s sel busy
        add(in_t'{2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0});
        add(in_t'{2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1});
        add(in_t'{2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b01,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1});
        add(in_t'{2'b10,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1});
        add(in_t'{2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1});
        add(in_t'{2'b10,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1});
        add(in_t'{2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0});
        add(in_t'{2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b10,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1});
        add(in_t'{2'b00,2'b00,2'b00,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1});
        add(in_t'{2'b01,2'b01,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0});
        add(in_t'{2'b01,2'b01,2'b00,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0},
            out_t'{2'b00,2'b01,2'b00,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1});
        add(in_t'{2'b01,2'b00,2'b01,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b01,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1});
        add(in_t'{2'b01,2'b00,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1});
        add(in_t'{2'b01,2'b00,2'b01,2'b01,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b01,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1});
        add(in_t'{2'b01,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1});
        add(in_t'{2'b01,2'b00,2'b00,2'b00,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1});
        add(in_t'{2'b01,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0});
        add(in_t'{2'b01,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b01,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1});
        add(in_t'{2'b00,2'b00,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b01,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1});
        add(in_t'{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0});
        add(in_t'{2'b10,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0});
        add(in_t'{2'b00,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1});
        add(in_t'{2'b01,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1});
        add(in_t'{2'b11,2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b10,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1});
        add(in_t'{2'b01,2'b00,2'b00,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1});
        add(in_t'{2'b01,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0});
        add(in_t'{2'b01,2'b00,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0},
            out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1});

        // Reset with every input active: all outputs must stay low
        ARESETn = 1'b0;
        drive('1);
        repeat (2) @(posedge ACLK);
        #1;
        check_out("reset_outputs", sample(), '0);
        ARESETn = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].i);
            @(negedge ACLK);
            check_out($sformatf("table[%0d]", k), sample(), tbl[k].o);
            tick();
        end

        // 4-beat read with RREADY toggling 1,0,1,0,1,1
        do_reset();
        v = '0;
        v.arv = 2'b01;
        drive(v);
        tick();
        v.ars = 1'b1;
        drive(v);
        @(negedge ACLK);
        check_out("seqA_ar", sample(),
                  out_t'{2'b01,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1});
        tick();
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        beats = 0;
        v = '0;
        v.rvs = 1'b1;
        for (int k = 0; k < 6; k++) begin
            v.rr  = {1'b0, pat[k]};
            v.rls = (k == 5);
            drive(v);
            @(negedge ACLK);
            o = sample();
            if (o.rv[0] && o.rr_s) beats++;
            tick();
        end
        check_int("seqA_beats", beats, 4);
        v = '0;
        drive(v);
        @(negedge ACLK);
        check_int("seqA_idle_after_rlast", int'(BUSY), 0);
        tick();

        // Asynchronous reset during write beat 2, then a tie after release
        do_reset();
        v = '0;
        v.awv = 2'b01;
        drive(v);
        tick();
        v.aws = 1'b1;
        drive(v);
        tick();
        v = '0;
        v.wv = 2'b01;
        v.ws = 1'b1;
        drive(v);
        tick();
        #2;
        ARESETn = 1'b0;
        #1;
        check_out("seqB_async_reset", sample(), '0);
        tick();
        v.arv = 2'b11;
        drive(v);
        ARESETn = 1'b1;
        @(negedge ACLK);
        check_out("seqB_release_idle", sample(), '0);
        tick();
        @(negedge ACLK);
        check_out("seqB_tie_grant_m0", sample(),
                  out_t'{2'b00,2'b00,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1});
        tick();

        // M1 write held pending while M0 reads back to back: grants alternate
        do_reset();
        v = '1;
        v.arv = 2'b01;
        v.awv = 2'b10;
        drive(v);
        prev_busy = 1'b0;
        for (int c = 0; c < 80 && grants.size() < 4; c++) begin
            @(negedge ACLK);
            o = sample();
            if (o.busy && !prev_busy) grants.push_back(int'(o.sel));
            prev_busy = o.busy;
            tick();
        end
        check_int("seqC_grant_count", grants.size(), 4);
        for (int k = 0; k < grants.size(); k++)
            check_int($sformatf("seqC_grant[%0d]", k), grants[k], k % 2);

        // Random traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            v.arv = 2'($urandom);
            v.awv = 2'($urandom);
            v.wv  = 2'($urandom);
            v.wl  = 2'($urandom);
            v.rr  = 2'($urandom);
            v.br  = 2'($urandom);
            v.ars = 1'($urandom);
            v.aws = 1'($urandom);
            v.ws  = 1'($urandom);
            v.rvs = 1'($urandom);
            v.rls = ($urandom_range(0, 2) == 0);
            v.bvs = 1'($urandom);
            drive(v);
            @(negedge ACLK);
            check_out($sformatf("random[%0d]", c), sample(), model_out(v));
            model_step(v);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_slave_arbiter.md
AXI_SLAVE_ARBITER -- requirements
Module: axi_slave_arbiter

Interface
REQ-001 Parameter WR_FIRST, default 1, within one master a pending write beats a pending read when 1; read beats write when 0.
REQ-002 The block SHALL have one clock, ACLK; reset ARESETn SHALL be asynchronous and active-low.
REQ-003 ACLK  in  1  clock; all state on rising edge.
REQ-004 ARESETn  in  1  asynchronous active-low reset.
REQ-005 ARVALID_M  in  2  read-address valid, bit i = master i.
REQ-006 ARREADY_M  out  2  read-address ready to master i.
REQ-007 AWVALID_M  in  2  write-address valid per master.
REQ-008 AWREADY_M  out  2  write-address ready per master.
REQ-009 WVALID_M  in  2  write-data valid per master.
REQ-010 WLAST_M  in  2  write-data last beat per master.
REQ-011 WREADY_M  out  2  write-data ready per master.
REQ-012 RVALID_M  out  2  read-data valid per master.
REQ-013 RREADY_M  in  2  read-data ready per master.
REQ-014 BVALID_M  out  2  write-response valid per master.
REQ-015 BREADY_M  in  2  write-response ready per master.
REQ-016 ARVALID_S / AWVALID_S / WVALID_S / RREADY_S / BREADY_S  out  1 each  handshake signals to the slave.
REQ-017 ARREADY_S / AWREADY_S / WREADY_S / RVALID_S / RLAST_S / BVALID_S  in  1 each  handshake signals from the slave.
REQ-018 SEL_M  out  1  granted master index; external payload muxes (address, ID, LEN, data, STRB, WLAST) key on it.
REQ-019 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, AR, RDATA, AW, WDATA, BRESP; one transaction owns the slave from grant until its final handshake.
REQ-021 IDLE: a master is eligible when it asserts any of ARVALID_M[i] or AWVALID_M[i]; if both masters are eligible, grant the master != LAST (round-robin pointer).
REQ-022 Within the granted master, select write or read per WR_FIRST; go to AW or AR; load SEL_M and set LAST = granted index on the same edge.
REQ-023 Grant latency: request sampled in IDLE at edge n, so ARVALID_S or AWVALID_S rises in cycle n+1.
REQ-024 AR: ARVALID_S = ARVALID_M[SEL_M]; ARREADY_M[SEL_M] = ARREADY_S; other bit 0; on ARVALID_S&&ARREADY_S go to RDATA.
REQ-025 RDATA: RVALID_M[SEL_M] = RVALID_S; RREADY_S = RREADY_M[SEL_M]; on RVALID_S&&RREADY_S&&RLAST_S go to IDLE.
REQ-026 AW: same rule as AR for the AW signals; on handshake go to WDATA.
REQ-027 WDATA: WVALID_S = WVALID_M[SEL_M]; WREADY_M[SEL_M] = WREADY_S; on handshake with WLAST_M[SEL_M]=1 go to BRESP.
REQ-028 BRESP: BVALID_M[SEL_M] = BVALID_S; BREADY_S = BREADY_M[SEL_M]; on handshake go to IDLE.
REQ-029 In every state the non-selected master's ready/valid outputs SHALL be 0; in IDLE all master-side and slave-side outputs SHALL be 0.
REQ-030 IDLE always lasts at least one cycle between transactions; requests present on the completing edge are arbitrated in the following IDLE cycle.
REQ-031 If the granted master drops its valid while in AR or AW, the FSM SHALL hold the state with no regrant; the other master's requests stay pending.
REQ-032 Slave beats arriving outside the matching state (for example RVALID_S in IDLE) SHALL be ignored and SHALL NOT be forwarded.

Reset
REQ-033 While ARESETn=0: state=IDLE, LAST=1 (so master 0 wins the first tie), SEL_M=0, BUSY=0, all valid/ready outputs 0.
REQ-034 Reset asserted mid-transaction SHALL abort immediately; no partial handshake is forwarded after release.

Verification
REQ-035 Both masters assert ARVALID_M=2'b11 after reset -> SEL_M=0, ARVALID_S=1 one cycle later; M1 is granted after M0's RLAST handshake plus one IDLE cycle.
REQ-036 M0 asserts ARVALID and AWVALID together, WR_FIRST=1 -> AW state, AWREADY_M=2'b01 follows AWREADY_S; run a 4-beat write, then BRESP, then the read.
REQ-037 4-beat read with RREADY_M[0] toggling 1,0,1,0,1,1 -> exactly 4 forwarded beats; IDLE reached on the edge after the RLAST handshake.
REQ-038 M1 holds a write pending while M0 issues back-to-back reads -> grants alternate M0,M1,M0; no master is granted twice in a row when both are pending.
REQ-039 ARESETn pulsed low in WDATA beat 2 -> all outputs 0 asynchronously; after release, the first IDLE cycle grants master 0 on a tie.
REQ-040 RVALID_S=1 injected during IDLE and AW -> RVALID_M stays 2'b00.
